// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Purpose:
//   Arbitrates between the instruction-fetch unit and the load/store unit
//   for the single shared memory port. It sequences the readM/inputReady
//   read handshake and the writeM/ackOutput write handshake, owns the
//   bidirectional data bus, and returns read data to the winning requester
//   with a one-cycle done pulse.
//
// Configuration macro:
//   ARB_ROUND_ROBIN_EN - when defined, simultaneous fetch and data requests
//                        alternate based on the last granted requester.
//                        When undefined, data always beats fetch and no
//                        last-grant register exists.
//
// Ports:
//   clk         - single clock, rising edge
//   reset_n     - synchronous reset, ACTIVE HIGH despite the name
//   if_req      - fetch read request, held until if_done
//   if_addr     - fetch address
//   if_done     - one-cycle fetch completion pulse
//   if_rdata    - last fetched word, held between requests
//   d_req       - data request, held until d_done
//   d_we        - 1 = write, 0 = read
//   d_addr      - data address
//   d_wdata     - store data
//   d_done      - one-cycle data completion pulse
//   d_rdata     - last loaded word, held between requests
//   readM       - memory read strobe
//   writeM      - memory write strobe
//   address     - memory address, holds its last value between transfers
//   data        - bidirectional bus, driven only while writeM is high
//   inputReady  - memory read data valid
//   ackOutput   - memory write acknowledge
module mem_port_arbiter #(
  parameter int WORD_SIZE = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 if_req,
  input  logic [WORD_SIZE-1:0] if_addr,
  output logic                 if_done,
  output logic [WORD_SIZE-1:0] if_rdata,
  input  logic                 d_req,
  input  logic                 d_we,
  input  logic [WORD_SIZE-1:0] d_addr,
  input  logic [WORD_SIZE-1:0] d_wdata,
  output logic                 d_done,
  output logic [WORD_SIZE-1:0] d_rdata,
  output logic                 readM,
  output logic                 writeM,
  output logic [WORD_SIZE-1:0] address,
  inout  wire  [WORD_SIZE-1:0] data,
  input  logic                 inputReady,
  input  logic                 ackOutput
);

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR,
    RELEASE
  } state_t;

  state_t               r_state;
  logic                 r_grantData;
  logic [WORD_SIZE-1:0] r_wdata;
  logic                 w_grantData;

`ifdef ARB_ROUND_ROBIN_EN
  // Remembers whether the data requester won the most recent grant, so a
  // contended IDLE hands the port to whichever side was passed over last.
  logic                 r_lastGrantData;

  always_comb begin
    w_grantData = d_req & (~if_req | ~r_lastGrantData);
  end
`else
  // Fixed priority: any pending data request beats a fetch.
  always_comb begin
    w_grantData = d_req;
  end
`endif

  // The bus is released whenever writeM is low, so it goes high-Z on the
  // same edge that ends a write or applies reset.
  assign data = writeM ? r_wdata : {WORD_SIZE{1'bz}};

  // Single-process FSM with registered strobes, address and done pulses.
  // RELEASE doubles as the reset state so a strobe left high by memory
  // after an abandoned or finished transfer can never complete a new one.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      r_state     <= RELEASE;
      readM       <= 1'b0;
      writeM      <= 1'b0;
      address     <= '0;
      if_done     <= 1'b0;
      d_done      <= 1'b0;
      if_rdata    <= '0;
      d_rdata     <= '0;
      r_grantData <= 1'b0;
      r_wdata     <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      r_lastGrantData <= 1'b0;
`endif
    end else begin
      if_done <= 1'b0;
      d_done  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (if_req || d_req) begin
            r_grantData <= w_grantData;
`ifdef ARB_ROUND_ROBIN_EN
            r_lastGrantData <= w_grantData;
`endif
            if (w_grantData) begin
              address <= d_addr;
              if (d_we) begin
                r_wdata <= d_wdata;
                writeM  <= 1'b1;
                r_state <= WR;
              end else begin
                readM   <= 1'b1;
                r_state <= RD;
              end
            end else begin
              // Fetch is always a read.
              address <= if_addr;
              readM   <= 1'b1;
              r_state <= RD;
            end
          end
        end
        RD: begin
          if (inputReady) begin
            if (r_grantData) begin
              d_rdata <= data;
              d_done  <= 1'b1;
            end else begin
              if_rdata <= data;
              if_done  <= 1'b1;
            end
            readM   <= 1'b0;
            r_state <= RELEASE;
          end
        end
        WR: begin
          if (ackOutput) begin
            d_done  <= 1'b1;
            writeM  <= 1'b0;
            r_state <= RELEASE;
          end
        end
        RELEASE: begin
          if (!inputReady && !ackOutput) begin
            r_state <= IDLE;
          end
        end
        default: begin
          r_state <= RELEASE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//
// Self-checking bench for mem_port_arbiter. A behavioural memory responder
// answers the strobes with configurable latency and strobe hold time.
// Directed vectors come from a table, multi-cycle corner cases are written
// out by hand, and a randomized phase is checked against a transaction-level
// model of the arbitration order and memory contents.
module tb_mem_port_arbiter;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         if_req;
  logic [W-1:0] if_addr;
  logic         if_done;
  logic [W-1:0] if_rdata;
  logic         d_req;
  logic         d_we;
  logic [W-1:0] d_addr;
  logic [W-1:0] d_wdata;
  logic         d_done;
  logic [W-1:0] d_rdata;
  logic         readM;
  logic         writeM;
  logic [W-1:0] address;
  wire  [W-1:0] data;
  logic         inputReady;
  logic         ackOutput;

  logic         memDriveEn;
  logic [W-1:0] memRdata;

  assign data = memDriveEn ? memRdata : {W{1'bz}};

  always #5 clk = ~clk;

  mem_port_arbiter #(.WORD_SIZE(W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .if_req     (if_req),
    .if_addr    (if_addr),
    .if_done    (if_done),
    .if_rdata   (if_rdata),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_done     (d_done),
    .d_rdata    (d_rdata),
    .readM      (readM),
    .writeM     (writeM),
    .address    (address),
    .data       (data),
    .inputReady (inputReady),
    .ackOutput  (ackOutput)
  );

  int checks = 0;
  int failures = 0;

  // Memory contents seen by the responder, and the model's own copy.
  logic [W-1:0] memArr [logic [W-1:0]];
  logic [W-1:0] refMem [logic [W-1:0]];

  bit           memAuto;
  int           memLat;
  int           memHold;
  int           rdWait;
  int           wrWait;
  int           rdHoldCnt;
  int           wrHoldCnt;
  logic [W-1:0] memLastAddr;
  logic [W-1:0] memLastWdata;
  int           ifDoneCnt;
  int           dDoneCnt;

  typedef struct {
    bit           isData;
    bit           we;
    logic [W-1:0] addr;
    logic [W-1:0] wdata;
    bit           doPreload;
    logic [W-1:0] preload;
    int           lat;
    logic [W-1:0] expData;
  } vec_t;

  vec_t vecs[7];

  // Words never written read back as a fixed scramble of their address.
  function automatic logic [W-1:0] defaultWord(input logic [W-1:0] a);
    return a ^ 16'h3C5A;
  endfunction

  function automatic logic [W-1:0] memRead(input logic [W-1:0] a);
    if (memArr.exists(a)) return memArr[a];
    return defaultWord(a);
  endfunction

  function automatic logic [W-1:0] refRead(input logic [W-1:0] a);
    if (refMem.exists(a)) return refMem[a];
    return defaultWord(a);
  endfunction

  // Compare one observed value against its expectation.
  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Memory side: raise inputReady/ackOutput memLat cycles after the strobe
  // is seen, then hold the response for memHold cycles after the strobe falls.
  task automatic memRespond();
    if (readM && !inputReady) begin
      rdWait++;
      if (rdWait >= memLat) begin
        inputReady  = 1'b1;
        memDriveEn  = 1'b1;
        memRdata    = memRead(address);
        memLastAddr = address;
      end
    end else if (!readM) begin
      rdWait = 0;
      if (inputReady) begin
        if (rdHoldCnt >= memHold) begin
          inputReady = 1'b0;
          memDriveEn = 1'b0;
          rdHoldCnt  = 0;
        end else begin
          rdHoldCnt++;
        end
      end
    end
    if (writeM && !ackOutput) begin
      wrWait++;
      if (wrWait >= memLat) begin
        ackOutput       = 1'b1;
        memArr[address] = data;
        memLastAddr     = address;
        memLastWdata    = data;
      end
    end else if (!writeM) begin
      wrWait = 0;
      if (ackOutput) begin
        if (wrHoldCnt >= memHold) begin
          ackOutput = 1'b0;
          wrHoldCnt = 0;
        end else begin
          wrHoldCnt++;
        end
      end
    end
  endtask

  // Advance to the next falling edge, check the always-true invariants,
  // count done pulses and let the memory respond.
  task automatic step();
    @(negedge clk);
    checks++;
    if ((readM && writeM) || (if_done && d_done)) begin
      failures++;
      $display("[TB] FAIL overlap: readM=%b writeM=%b if_done=%b d_done=%b, expected at most one of each pair", readM, writeM, if_done, d_done);
    end
    if (if_done) ifDoneCnt++;
    if (d_done) dDoneCnt++;
    if (memAuto) memRespond();
  endtask

  task automatic doReset();
    reset_n = 1'b1;
    if_req  = 1'b0;
    d_req   = 1'b0;
    step();
    step();
    reset_n = 1'b0;
    step();
  endtask

  // Present one table vector as a single uncontended request.
  task automatic applyStimulus(input vec_t v);
    memLat = v.lat;
    memHold = 0;
    if (v.doPreload) memArr[v.addr] = v.preload;
    if (v.isData) begin
      d_req   = 1'b1;
      d_we    = v.we;
      d_addr  = v.addr;
      d_wdata = v.wdata;
    end else begin
      if_req  = 1'b1;
      if_addr = v.addr;
    end
  endtask

  initial begin
    bit           done;
    int           lat;
    int           order[$];
    int           serve[$];
    bit           reRaised;
    bit           raisePending;
    int           o0;
    int           o1;
    int           o2;
    bit           rrLastData;
    int           sel;
    bit           wantIf;
    bit           wantD;
    bit           we;
    logic [W-1:0] ia;
    logic [W-1:0] da;
    logic [W-1:0] wd;
    logic [W-1:0] expIf;
    logic [W-1:0] expD;

    reset_n    = 1'b1;
    if_req     = 1'b0;
    if_addr    = '0;
    d_req      = 1'b0;
    d_we       = 1'b0;
    d_addr     = '0;
    d_wdata    = '0;
    inputReady = 1'b0;
    ackOutput  = 1'b0;
    memDriveEn = 1'b0;
    memRdata   = '0;
    memAuto    = 1'b1;
    memLat     = 1;
    memHold    = 0;
    rdWait     = 0;
    wrWait     = 0;
    rdHoldCnt  = 0;
    wrHoldCnt  = 0;
    ifDoneCnt  = 0;
    dDoneCnt   = 0;
    memLastAddr  = '0;
    memLastWdata = '0;

    // Reset state.
    step();
    checkOutput("reset readM", {15'd0, readM}, 16'd0);
    checkOutput("reset writeM", {15'd0, writeM}, 16'd0);
    checkOutput("reset address", address, 16'h0000);
    checkOutput("reset dones", {14'd0, if_done, d_done}, 16'd0);
    checkOutput("reset if_rdata", if_rdata, 16'h0000);
    checkOutput("reset d_rdata", d_rdata, 16'h0000);
    step();
    reset_n = 1'b0;
    step();

    // Directed single-transfer vectors.
    vecs[0] = '{isData:0, we:0, addr:16'h0010, wdata:16'h0000, doPreload:1, preload:16'h6C05, lat:3, expData:16'h6C05};
    vecs[1] = '{isData:1, we:1, addr:16'h0042, wdata:16'hBEEF, doPreload:0, preload:16'h0000, lat:2, expData:16'hBEEF};
    vecs[2] = '{isData:1, we:0, addr:16'h0042, wdata:16'h0000, doPreload:0, preload:16'h0000, lat:1, expData:16'hBEEF};
    vecs[3] = '{isData:0, we:0, addr:16'hFFFF, wdata:16'h0000, doPreload:1, preload:16'h0000, lat:1, expData:16'h0000};
    vecs[4] = '{isData:1, we:0, addr:16'h0000, wdata:16'h0000, doPreload:1, preload:16'hFFFF, lat:4, expData:16'hFFFF};
    vecs[5] = '{isData:1, we:1, addr:16'hFFFF, wdata:16'h0001, doPreload:0, preload:16'h0000, lat:1, expData:16'h0001};
    vecs[6] = '{isData:0, we:0, addr:16'hFFFF, wdata:16'h0000, doPreload:0, preload:16'h0000, lat:2, expData:16'h0001};

    for (int v = 0; v < 7; v++) begin
      ifDoneCnt = 0;
      dDoneCnt  = 0;
      done = 1'b0;
      lat  = 0;
      applyStimulus(vecs[v]);
      for (int c = 1; c <= 30 && !done; c++) begin
        step();
        if (c == 1) begin
          checkOutput($sformatf("vec%0d strobe", v), {14'd0, readM, writeM},
                      (vecs[v].isData && vecs[v].we) ? 16'd1 : 16'd2);
          checkOutput($sformatf("vec%0d address", v), address, vecs[v].addr);
        end
        if (vecs[v].isData ? d_done : if_done) begin
          done = 1'b1;
          lat  = c;
          if_req = 1'b0;
          d_req  = 1'b0;
        end
      end
      checkOutput($sformatf("vec%0d latency", v), 16'(lat), 16'(vecs[v].lat + 1));
      if (vecs[v].isData && vecs[v].we)
        checkOutput($sformatf("vec%0d bus data", v), memLastWdata, vecs[v].expData);
      else if (vecs[v].isData)
        checkOutput($sformatf("vec%0d d_rdata", v), d_rdata, vecs[v].expData);
      else
        checkOutput($sformatf("vec%0d if_rdata", v), if_rdata, vecs[v].expData);
      for (int s = 0; s < 3; s++) step();
      checkOutput($sformatf("vec%0d strobes low", v), {14'd0, readM, writeM}, 16'd0);
      checkOutput($sformatf("vec%0d done counts", v), {8'(ifDoneCnt), 8'(dDoneCnt)},
                  vecs[v].isData ? 16'h0001 : 16'h0100);
      checkOutput($sformatf("vec%0d address held", v), address, vecs[v].addr);
    end

    // Contention: both raised, then data re-raised while fetch still waits.
    doReset();
    memLat  = 1;
    memHold = 0;
    memArr[16'h0100] = 16'h1111;
    memArr[16'h0200] = 16'h2222;
    memArr[16'h0300] = 16'h3333;
    order.delete();
    reRaised = 1'b0;
    raisePending = 1'b0;
    if_req  = 1'b1;
    if_addr = 16'h0100;
    d_req   = 1'b1;
    d_we    = 1'b0;
    d_addr  = 16'h0200;
    for (int c = 0; c < 60 && order.size() < 3; c++) begin
      step();
      if (raisePending) begin
        d_req  = 1'b1;
        d_addr = 16'h0300;
        raisePending = 1'b0;
      end
      if (d_done) begin
        order.push_back(1);
        d_req = 1'b0;
        if (!reRaised) begin
          reRaised = 1'b1;
          raisePending = 1'b1;
        end
      end
      if (if_done) begin
        order.push_back(0);
        if_req = 1'b0;
      end
    end
    o0 = (order.size() > 0) ? order[0] : 9;
    o1 = (order.size() > 1) ? order[1] : 9;
    o2 = (order.size() > 2) ? order[2] : 9;
    checkOutput("contention first grant", 16'(o0), 16'd1);
`ifdef ARB_ROUND_ROBIN_EN
    checkOutput("contention second grant", 16'(o1), 16'd0);
    checkOutput("contention third grant", 16'(o2), 16'd1);
`else
    checkOutput("contention second grant", 16'(o1), 16'd1);
    checkOutput("contention third grant", 16'(o2), 16'd0);
`endif
    checkOutput("contention if_rdata", if_rdata, 16'h1111);
    checkOutput("contention d_rdata", d_rdata, 16'h3333);
    for (int s = 0; s < 3; s++) step();

    // Stale strobe: inputReady lingers after a read while a new fetch waits.
    memLat  = 1;
    memHold = 4;
    memArr[16'h0030] = 16'hA5A5;
    memArr[16'h0031] = 16'h5A5A;
    ifDoneCnt = 0;
    if_req  = 1'b1;
    if_addr = 16'h0030;
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      step();
      if (if_done) begin
        done = 1'b1;
        if_req = 1'b0;
      end
    end
    checkOutput("stale first if_rdata", if_rdata, 16'hA5A5);
    step();
    if_req  = 1'b1;
    if_addr = 16'h0031;
    for (int c = 0; c < 20 && inputReady; c++) begin
      step();
      checkOutput("stale readM held low", {15'd0, readM}, 16'd0);
      checkOutput("stale no extra done", 16'(ifDoneCnt), 16'd1);
    end
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      step();
      if (if_done) begin
        done = 1'b1;
        if_req = 1'b0;
      end
    end
    checkOutput("stale second fetch address", memLastAddr, 16'h0031);
    checkOutput("stale second if_rdata", if_rdata, 16'h5A5A);
    checkOutput("stale done count", 16'(ifDoneCnt), 16'd2);
    memHold = 0;
    for (int s = 0; s < 8; s++) step();

    // Reset in the middle of a read, with inputReady arriving during reset.
    memAuto = 1'b0;
    memArr[16'h0020] = 16'h2020;
    ifDoneCnt = 0;
    if_req  = 1'b1;
    if_addr = 16'h0020;
    step();
    checkOutput("midreset readM raised", {15'd0, readM}, 16'd1);
    step();
    reset_n    = 1'b1;
    inputReady = 1'b1;
    memDriveEn = 1'b1;
    memRdata   = 16'h9999;
    step();
    checkOutput("midreset readM dropped", {15'd0, readM}, 16'd0);
    checkOutput("midreset if_rdata", if_rdata, 16'h0000);
    step();
    reset_n = 1'b0;
    for (int s = 0; s < 3; s++) begin
      step();
      checkOutput("midreset readM while stale", {15'd0, readM}, 16'd0);
    end
    checkOutput("midreset no done", 16'(ifDoneCnt), 16'd0);
    inputReady = 1'b0;
    memDriveEn = 1'b0;
    rdWait    = 0;
    rdHoldCnt = 0;
    memAuto   = 1'b1;
    memLat    = 1;
    done = 1'b0;
    for (int c = 0; c < 20 && !done; c++) begin
      step();
      if (if_done) begin
        done = 1'b1;
        if_req = 1'b0;
      end
    end
    checkOutput("midreset resumed if_rdata", if_rdata, 16'h2020);
    checkOutput("midreset resumed done count", 16'(ifDoneCnt), 16'd1);

    // Randomized rounds against a transaction-level model: the model decides
    // the service order from the arbitration rule and replays the memory
    // effects in that order to predict every returned word.
    doReset();
    rrLastData = 1'b0;
    refMem = memArr;
    for (int t = 0; t < 50; t++) begin
      sel    = int'($urandom_range(1, 3));
      wantIf = sel[0];
      wantD  = sel[1];
      we     = 1'($urandom_range(0, 1));
      ia     = 16'($urandom_range(0, 7));
      da     = 16'($urandom_range(0, 7));
      wd     = 16'($urandom);
      memLat  = int'($urandom_range(1, 4));
      memHold = int'($urandom_range(0, 2));
      expIf = '0;
      expD  = '0;

      serve.delete();
      if (wantIf && wantD) begin
`ifdef ARB_ROUND_ROBIN_EN
        if (rrLastData) serve = '{0, 1};
        else serve = '{1, 0};
`else
        serve = '{1, 0};
`endif
      end else begin
        serve.push_back(wantD ? 1 : 0);
      end
      foreach (serve[k]) begin
        if (serve[k] == 1) begin
          if (we) refMem[da] = wd;
          else expD = refRead(da);
        end else begin
          expIf = refRead(ia);
        end
        rrLastData = (serve[k] == 1);
      end

      ifDoneCnt = 0;
      dDoneCnt  = 0;
      order.delete();
      if_req  = wantIf;
      if_addr = ia;
      d_req   = wantD;
      d_we    = we;
      d_addr  = da;
      d_wdata = wd;
      for (int c = 0; c < 80 && order.size() < serve.size(); c++) begin
        step();
        if (if_done) begin
          order.push_back(0);
          if_req = 1'b0;
        end
        if (d_done) begin
          order.push_back(1);
          d_req = 1'b0;
        end
      end
      for (int s = 0; s < 6; s++) step();

      checkOutput($sformatf("rand%0d if_done count", t), 16'(ifDoneCnt), 16'(wantIf));
      checkOutput($sformatf("rand%0d d_done count", t), 16'(dDoneCnt), 16'(wantD));
      o0 = (order.size() > 0) ? order[0] : 9;
      checkOutput($sformatf("rand%0d first served", t), 16'(o0), 16'(serve[0]));
      if (wantIf) checkOutput($sformatf("rand%0d if_rdata", t), if_rdata, expIf);
      if (wantD && !we) checkOutput($sformatf("rand%0d d_rdata", t), d_rdata, expD);
      if (wantD && we) checkOutput($sformatf("rand%0d stored word", t), memRead(da), wd);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
